// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle RV32I core: combinational word reads,
// byte-lane stores, sticky error flags. Define DMEM_MMIO_EN to add the MMIO window.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] memory_address,
   input  logic [31:0] data_to_write,
   input  logic [2:0]  func3,
   input  logic        write_data,
   output logic [31:0] read_data,
   output logic [31:0] tohost,
   output logic        done,
   output logic        misalign_err,
   output logic        range_err
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

   logic [31:0] r_mem [DEPTH_WORDS];
   logic        r_misalign;
   logic        r_range;
   logic [15:0] r_err_cnt;

   logic [AW-1:0] w_idx;
   logic          w_mmio_hit;
   logic          w_mmio_sel;
   logic          w_ram_hit;
   logic          w_size_ok;
   logic          w_aligned;
   logic          w_range_fault;
   logic          w_misalign_fault;
   logic          w_ram_we;
   logic          w_status_clr;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic [31:0]   w_rdata;

   assign w_idx      = memory_address[AW+1:2];
   assign w_mmio_hit = (memory_address[31:4] == MMIO_BASE[31:4]);
   // MMIO window wins if a configuration ever overlaps it with RAM
   assign w_ram_hit  = ({1'b0, memory_address} < RAM_BYTES) && !w_mmio_hit;

`ifdef DMEM_MMIO_EN
   logic [63:0] r_cycle;
   logic [31:0] r_tohost;
   logic        w_mmio_we;

   assign w_mmio_sel   = w_mmio_hit;
   assign w_mmio_we    = write_data && w_mmio_hit && (func3 == 3'b010) &&
                         (memory_address[1:0] == 2'b00);
   assign w_status_clr = w_mmio_we && (memory_address[3:2] == 2'b11);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle  <= '0;
         r_tohost <= '0;
      end else begin
         r_cycle <= r_cycle + 64'd1;
         if (w_mmio_we && (memory_address[3:2] == 2'b10))
            r_tohost <= data_to_write;
      end
   end

   assign tohost = r_tohost;
   assign done   = (r_tohost != 32'd0);
`else
   assign w_mmio_sel   = 1'b0;
   assign w_status_clr = 1'b0;
   assign tohost       = '0;
   assign done         = 1'b0;
`endif

   always_comb begin
      w_size_ok = 1'b1;
      w_aligned = 1'b1;
      w_be      = 4'b1111;
      w_wdata   = data_to_write;
      case (func3)
         3'b000: begin
            w_be    = 4'b0001 << memory_address[1:0];
            w_wdata = {4{data_to_write[7:0]}};
         end
         3'b001: begin
            w_aligned = !memory_address[0];
            w_be      = memory_address[1] ? 4'b1100 : 4'b0011;
            w_wdata   = {2{data_to_write[15:0]}};
         end
         3'b010: w_aligned = (memory_address[1:0] == 2'b00);
         default: begin
            w_size_ok = 1'b0;
            w_aligned = 1'b0;
         end
      endcase
   end

   // Range faults take precedence: illegal size, unmapped, or sub-word MMIO access
   assign w_range_fault    = write_data && (!w_size_ok || (!w_ram_hit && !w_mmio_sel) ||
                                            (w_mmio_sel && (func3 != 3'b010)));
   assign w_misalign_fault = write_data && !w_range_fault && !w_aligned;
   assign w_ram_we         = write_data && rst_n && w_ram_hit && w_size_ok && w_aligned;

   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b])
               r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_misalign <= 1'b0;
         r_range    <= 1'b0;
         r_err_cnt  <= '0;
      end else if (w_status_clr) begin
         r_misalign <= 1'b0;
         r_range    <= 1'b0;
         r_err_cnt  <= '0;
      end else if (w_range_fault || w_misalign_fault) begin
         if (w_range_fault)
            r_range <= 1'b1;
         if (w_misalign_fault)
            r_misalign <= 1'b1;
         if (r_err_cnt != 16'hFFFF)
            r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   always_comb begin
      w_rdata = '0;
      if (w_ram_hit) begin
         w_rdata = r_mem[w_idx];
      end
`ifdef DMEM_MMIO_EN
      else if (w_mmio_hit) begin
         case (memory_address[3:2])
            2'b00:   w_rdata = r_cycle[31:0];
            2'b01:   w_rdata = r_cycle[63:32];
            2'b10:   w_rdata = r_tohost;
            default: w_rdata = {r_err_cnt, 14'd0, r_range, r_misalign};
         endcase
      end
`endif
   end

   assign read_data    = w_rdata;
   assign misalign_err = r_misalign;
   assign range_err    = r_range;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder; MMIO scenarios run when DMEM_MMIO_EN is defined.
module tb_dmem_responder;

   logic        clk;
   logic        rst_n;
   logic [31:0] memory_address;
   logic [31:0] data_to_write;
   logic [2:0]  func3;
   logic        write_data;
   logic [31:0] read_data;
   logic [31:0] tohost;
   logic        done;
   logic        misalign_err;
   logic        range_err;

   int n_total = 0;
   int n_pass  = 0;

   localparam logic [31:0] MMIO    = 32'hFFFF_0000;
   localparam logic [31:0] ST_ADDR = 32'hFFFF_000C;

   dmem_responder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .memory_address (memory_address),
      .data_to_write  (data_to_write),
      .func3          (func3),
      .write_data     (write_data),
      .read_data      (read_data),
      .tohost         (tohost),
      .done           (done),
      .misalign_err   (misalign_err),
      .range_err      (range_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      @(negedge clk);
      memory_address = a;
      data_to_write  = d;
      func3          = f;
      write_data     = 1'b1;
      @(posedge clk);
      #1;
      write_data = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      memory_address = a;
      #1;
      d = read_data;
   endtask

   task automatic clear_flags();
`ifdef DMEM_MMIO_EN
      do_store(ST_ADDR, 32'd0, 3'b010);
`else
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (tohost !== 32'd0) $display("FAIL reset_tohost got %h want 0", tohost); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_total++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign got %b want 0", misalign_err); else n_pass++;
      n_total++; if (range_err !== 1'b0) $display("FAIL reset_range got %b want 0", range_err); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_sw_sb();
      logic [31:0] v;
      do_store(32'h10, 32'h1122_3344, 3'b010);
      rd(32'h10, v);
      n_total++; if (v !== 32'h1122_3344) $display("FAIL sw_word got %h want 11223344", v); else n_pass++;
      do_store(32'h12, 32'h0000_00AA, 3'b000);
      rd(32'h10, v);
      n_total++; if (v !== 32'h11AA_3344) $display("FAIL sb_lane2 got %h want 11aa3344", v); else n_pass++;
      rd(32'h13, v);
      n_total++; if (v !== 32'h11AA_3344) $display("FAIL read_unshifted got %h want 11aa3344", v); else n_pass++;
      do_store(32'h13, 32'hFFFF_FF55, 3'b000);
      rd(32'h10, v);
      n_total++; if (v !== 32'h55AA_3344) $display("FAIL sb_lane3 got %h want 55aa3344", v); else n_pass++;
   endtask

   task automatic test_sh();
      logic [31:0] v;
      do_store(32'h20, 32'h0, 3'b010);
      do_store(32'h22, 32'h0000_BEEF, 3'b001);
      rd(32'h20, v);
      n_total++; if (v !== 32'hBEEF_0000) $display("FAIL sh_upper got %h want beef0000", v); else n_pass++;
      do_store(32'h20, 32'hAAAA_1234, 3'b001);
      rd(32'h20, v);
      n_total++; if (v !== 32'hBEEF_1234) $display("FAIL sh_lower got %h want beef1234", v); else n_pass++;
      do_store(32'h21, 32'h0000_5678, 3'b001);
      rd(32'h20, v);
      n_total++; if (v !== 32'hBEEF_1234) $display("FAIL sh_misaligned_word got %h want beef1234", v); else n_pass++;
      n_total++; if (misalign_err !== 1'b1) $display("FAIL sh_misalign_flag got %b want 1", misalign_err); else n_pass++;
      n_total++; if (range_err !== 1'b0) $display("FAIL sh_range_flag got %b want 0", range_err); else n_pass++;
`ifdef DMEM_MMIO_EN
      rd(ST_ADDR, v);
      n_total++; if (v !== 32'h0001_0001) $display("FAIL sh_status got %h want 00010001", v); else n_pass++;
`endif
   endtask

   task automatic test_illegal();
      logic [31:0] v;
      clear_flags();
      do_store(32'h24, 32'hCAFE_F00D, 3'b010);
      do_store(32'h26, 32'h1111_1111, 3'b010);
      rd(32'h24, v);
      n_total++; if (v !== 32'hCAFE_F00D) $display("FAIL sw_misaligned_word got %h want cafef00d", v); else n_pass++;
      n_total++; if (misalign_err !== 1'b1) $display("FAIL sw_misalign_flag got %b want 1", misalign_err); else n_pass++;
      n_total++; if (range_err !== 1'b0) $display("FAIL sw_misalign_range got %b want 0", range_err); else n_pass++;
      do_store(32'h24, 32'h2222_2222, 3'b011);
      rd(32'h24, v);
      n_total++; if (v !== 32'hCAFE_F00D) $display("FAIL bad_func3_word got %h want cafef00d", v); else n_pass++;
      n_total++; if (range_err !== 1'b1) $display("FAIL bad_func3_range got %b want 1", range_err); else n_pass++;
`ifdef DMEM_MMIO_EN
      rd(ST_ADDR, v);
      n_total++; if (v !== 32'h0002_0003) $display("FAIL illegal_status got %h want 00020003", v); else n_pass++;
`endif
   endtask

   task automatic test_range();
      logic [31:0] v;
      clear_flags();
      n_total++; if (range_err !== 1'b0) $display("FAIL clear_range got %b want 0", range_err); else n_pass++;
      do_store(32'h0000_1000, 32'hDEAD_BEEF, 3'b010);
      rd(32'h0000_1000, v);
      n_total++; if (v !== 32'd0) $display("FAIL unmapped_read got %h want 0", v); else n_pass++;
      n_total++; if (range_err !== 1'b1) $display("FAIL unmapped_range got %b want 1", range_err); else n_pass++;
      n_total++; if (misalign_err !== 1'b0) $display("FAIL unmapped_misalign got %b want 0", misalign_err); else n_pass++;
      rd(32'h0, v);
      n_total++; if (v !== 32'h0) begin
         // word 0 was never written; only check it is not the dropped data
         if (v === 32'hDEAD_BEEF) $display("FAIL wrap_alias got %h want not deadbeef", v); else n_pass++;
      end else n_pass++;
`ifdef DMEM_MMIO_EN
      rd(ST_ADDR, v);
      n_total++; if (v !== 32'h0001_0002) $display("FAIL range_status got %h want 00010002", v); else n_pass++;
      do_store(ST_ADDR, 32'hFFFF_FFFF, 3'b010);
      rd(ST_ADDR, v);
      n_total++; if (v !== 32'd0) $display("FAIL status_clear got %h want 0", v); else n_pass++;
      n_total++; if (range_err !== 1'b0) $display("FAIL status_clear_range got %b want 0", range_err); else n_pass++;
`else
      clear_flags();
      do_store(MMIO + 32'h8, 32'd1, 3'b010);
      rd(MMIO + 32'h8, v);
      n_total++; if (v !== 32'd0) $display("FAIL nommio_read got %h want 0", v); else n_pass++;
      n_total++; if (range_err !== 1'b1) $display("FAIL nommio_range got %b want 1", range_err); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL nommio_done got %b want 0", done); else n_pass++;
      n_total++; if (tohost !== 32'd0) $display("FAIL nommio_tohost got %h want 0", tohost); else n_pass++;
`endif
   endtask

`ifdef DMEM_MMIO_EN
   task automatic test_mmio();
      logic [31:0] v;
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      rd(MMIO, v);
      n_total++; if (v < 32'd99 || v > 32'd101) $display("FAIL cycle_lo got %0d want 100", v); else n_pass++;
      rd(MMIO + 32'h4, v);
      n_total++; if (v !== 32'd0) $display("FAIL cycle_hi got %h want 0", v); else n_pass++;
      do_store(MMIO + 32'h8, 32'd1, 3'b010);
      n_total++; if (done !== 1'b1) $display("FAIL tohost_done got %b want 1", done); else n_pass++;
      do_store(MMIO + 32'h8, 32'h0000_00FF, 3'b000);
      n_total++; if (tohost !== 32'd1) $display("FAIL sb_tohost got %h want 1", tohost); else n_pass++;
      n_total++; if (range_err !== 1'b1) $display("FAIL sb_tohost_range got %b want 1", range_err); else n_pass++;
      do_store(MMIO, 32'h1234_5678, 3'b010);
      n_total++; if (range_err !== 1'b1 || misalign_err !== 1'b0)
         $display("FAIL sw_cycle_err got %b%b want 10", range_err, misalign_err); else n_pass++;
      do_store(MMIO + 32'h8, 32'd0, 3'b010);
      n_total++; if (done !== 1'b0) $display("FAIL tohost_zero_done got %b want 0", done); else n_pass++;
   endtask
`endif

   task automatic test_reset_mid();
      logic [31:0] v;
`ifdef DMEM_MMIO_EN
      do_store(MMIO + 32'h8, 32'd5, 3'b010);
      n_total++; if (tohost !== 32'd5) $display("FAIL tohost_5 got %h want 5", tohost); else n_pass++;
`endif
      do_store(32'h21, 32'h0, 3'b001);
      do_store(32'h0000_2000, 32'h0, 3'b010);
      n_total++; if (misalign_err !== 1'b1 || range_err !== 1'b1)
         $display("FAIL pre_reset_flags got %b%b want 11", misalign_err, range_err); else n_pass++;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_total++; if (misalign_err !== 1'b0 || range_err !== 1'b0)
         $display("FAIL async_flags got %b%b want 00", misalign_err, range_err); else n_pass++;
      n_total++; if (tohost !== 32'd0 || done !== 1'b0)
         $display("FAIL async_tohost got %h/%b want 0/0", tohost, done); else n_pass++;
      rd(32'h10, v);
      n_total++; if (v !== 32'h55AA_3344) $display("FAIL ram_retained got %h want 55aa3344", v); else n_pass++;
      @(negedge clk);
      memory_address = 32'h10;
      data_to_write  = 32'h1234_5678;
      func3          = 3'b010;
      write_data     = 1'b1;
      @(posedge clk);
      #1;
      write_data = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rd(32'h10, v);
      n_total++; if (v !== 32'h55AA_3344) $display("FAIL store_in_reset got %h want 55aa3344", v); else n_pass++;
`ifdef DMEM_MMIO_EN
      rd(ST_ADDR, v);
      n_total++; if (v !== 32'd0) $display("FAIL status_after_reset got %h want 0", v); else n_pass++;
`endif
   endtask

   initial begin
      rst_n          = 1'b0;
      memory_address = '0;
      data_to_write  = '0;
      func3          = 3'b010;
      write_data     = 1'b0;
      test_reset();
      test_sw_sb();
      test_sh();
      test_illegal();
      test_range();
`ifdef DMEM_MMIO_EN
      test_mmio();
`endif
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
